// File: rtl/fp_calc_sequencer.sv
// Command sequencer for the FP calculator: issues one operation at a time, waits for the
// result (fixed latency or divide finish/timeout), returns it on a response handshake. Optional stats: FP_SEQ_STATS_EN.
module fp_calc_sequencer #(
    parameter int unsigned FIXED_LAT      = 3,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    output logic [31:0] calc_a,
    output logic [31:0] calc_b,
    output logic [1:0]  calc_op,
    output logic        calc_en,
    input  logic [31:0] calc_out,
    input  logic        calc_finish,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_op,
    output logic        rsp_timeout,
    output logic        busy,
    output logic [15:0] stat_done,
    output logic [15:0] stat_timeout
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic [7:0]  LAT_LAST = 8'(FIXED_LAT - 1);
    localparam logic [7:0]  TO_LAST  = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic        arm_q;
    logic [31:0] calc_a_q, calc_b_q, rsp_data_q;
    logic [1:0]  calc_op_q, rsp_op_q;
    logic        calc_en_q, rsp_valid_q, rsp_timeout_q, busy_q;
    logic        is_div, div_done, rsp_hs;

    assign is_div    = (calc_op_q == 2'b11);
    assign div_done  = arm_q & calc_finish;
    assign rsp_hs    = rsp_valid_q & rsp_ready;

    assign cmd_ready   = (state_q == S_IDLE);
    assign calc_a      = calc_a_q;
    assign calc_b      = calc_b_q;
    assign calc_op     = calc_op_q;
    assign calc_en     = calc_en_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_op      = rsp_op_q;
    assign rsp_timeout = rsp_timeout_q;
    assign busy        = busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            arm_q         <= 1'b0;
            calc_a_q      <= '0;
            calc_b_q      <= '0;
            calc_op_q     <= '0;
            calc_en_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_op_q      <= '0;
            rsp_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        calc_a_q  <= cmd_a;
                        calc_b_q  <= cmd_b;
                        calc_op_q <= cmd_op;
                        calc_en_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt_q   <= '0;
                    arm_q   <= 1'b0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + 8'd1;
                    // A finish still high from the previous divide must drop once before it counts
                    if (!calc_finish) arm_q <= 1'b1;
                    if ((!is_div && cnt_q == LAT_LAST) || (is_div && div_done)) begin
                        rsp_data_q    <= calc_out;
                        rsp_timeout_q <= 1'b0;
                        rsp_op_q      <= calc_op_q;
                        rsp_valid_q   <= 1'b1;
                        calc_en_q     <= 1'b0;
                        state_q       <= S_RESP;
                    end else if (is_div && cnt_q == TO_LAST) begin
                        rsp_data_q    <= QNAN;
                        rsp_timeout_q <= 1'b1;
                        rsp_op_q      <= calc_op_q;
                        rsp_valid_q   <= 1'b1;
                        calc_en_q     <= 1'b0;
                        state_q       <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef FP_SEQ_STATS_EN
    logic [15:0] stat_done_q, stat_timeout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_done_q    <= '0;
            stat_timeout_q <= '0;
        end else if (rsp_hs) begin
            if (rsp_timeout_q) begin
                if (stat_timeout_q != '1) stat_timeout_q <= stat_timeout_q + 16'd1;
            end else begin
                if (stat_done_q != '1) stat_done_q <= stat_done_q + 16'd1;
            end
        end
    end

    assign stat_done    = stat_done_q;
    assign stat_timeout = stat_timeout_q;
`else
    logic unused_hs;
    assign unused_hs    = rsp_hs;
    assign stat_done    = '0;
    assign stat_timeout = '0;
`endif

endmodule

// File: tb/tb_fp_calc_sequencer.sv
// Self-checking bench for fp_calc_sequencer: directed vector table, reset-in-WAIT sequence,
// and randomized transactions against a transaction-level reference model.
module tb_fp_calc_sequencer;

    localparam int unsigned LAT = 3;
    localparam int unsigned TO  = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_a, cmd_b;
    logic [31:0] calc_a, calc_b, calc_out;
    logic [1:0]  calc_op;
    logic        calc_en, calc_finish;
    logic        rsp_valid, rsp_ready, rsp_timeout, busy;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_op;
    logic [15:0] stat_done, stat_timeout;

    fp_calc_sequencer #(.FIXED_LAT(LAT), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .calc_a(calc_a), .calc_b(calc_b), .calc_op(calc_op), .calc_en(calc_en),
        .calc_out(calc_out), .calc_finish(calc_finish),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_op(rsp_op),
        .rsp_timeout(rsp_timeout), .busy(busy), .stat_done(stat_done), .stat_timeout(stat_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, res;
        int          stale, gap;
        bit          stuck;
        int          delay;
        logic [31:0] exp_data;
        bit          exp_to;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    int n_to   = 0;

    // Calculator model state, set by the driving task per transaction.
    logic [1:0]  cur_op = 2'b00;
    logic [31:0] cur_a = '0, cur_b = '0, cur_res = '0;
    int          cur_stale = 0, cur_gap = 1;
    bit          cur_stuck = 1'b0;
    int          en_cnt = 0;
    int          hold_err_cnt = 0;
    int          w;

    initial begin
        calc_out    = '0;
        calc_finish = 1'b0;
    end

    // en_cnt is 1 in the issue cycle, so WAIT cycle number is en_cnt-1.
    always @(negedge clk) begin
        if (calc_en) en_cnt = en_cnt + 1;
        else         en_cnt = 0;
        if (calc_en && (calc_a !== cur_a || calc_b !== cur_b || calc_op !== cur_op))
            hold_err_cnt = hold_err_cnt + 1;
        if (en_cnt > 0) begin
            w = en_cnt - 1;
            if (cur_op != 2'b11) begin
                calc_out    = (en_cnt >= int'(LAT) + 1) ? cur_res : 32'hDEADBEEF;
                calc_finish = 1'($urandom_range(0, 1));
            end else begin
                calc_out = (w > cur_stale) ? cur_res : 32'h11111111;
                if (w == 0)                          calc_finish = (cur_stale > 0);
                else if (w <= cur_stale)             calc_finish = 1'b1;
                else if (w <= cur_stale + cur_gap)   calc_finish = 1'b0;
                else                                 calc_finish = !cur_stuck;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Divide completes on the first finish=1 WAIT cycle preceded by a finish=0 WAIT cycle.
    function automatic int model_lat(input logic [1:0] op, input int stale, input int gap,
                                     input bit stuck, output bit to);
        int j;
        to = 1'b0;
        if (op != 2'b11) return int'(LAT) + 2;
        j = stuck ? 1 << 30 : stale + gap + 1;
        if (j <= int'(TO)) return j + 2;
        to = 1'b1;
        return int'(TO) + 2;
    endfunction

    task automatic run_txn(input vec_t v);
        int lat, exp_lat, herr0;
        bit got, rdy_err, stab_err, to;
        logic [31:0] d0;
        logic [1:0]  o0;
        logic        t0;
        cur_op = v.op; cur_a = v.a; cur_b = v.b; cur_res = v.res;
        cur_stale = v.stale; cur_gap = v.gap; cur_stuck = v.stuck;
        exp_lat = model_lat(v.op, v.stale, v.gap, v.stuck, to);
        herr0 = hold_err_cnt;
        @(negedge clk);
        chk("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_op = v.op; cmd_a = v.a; cmd_b = v.b;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; cmd_a = $urandom; cmd_b = $urandom; cmd_op = 2'($urandom);
        lat = 0; got = 1'b0; rdy_err = 1'b0;
        while (!got && lat < 400) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) got = 1'b1;
            else if (cmd_ready !== 1'b0 || busy !== 1'b1) rdy_err = 1'b1;
        end
        chk("latency", lat, exp_lat);
        if (!got) return;
        chk("rsp_data", rsp_data, v.exp_data);
        chk("rsp_op", {30'b0, rsp_op}, {30'b0, v.op});
        chk("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, v.exp_to});
        chk("model_timeout_agrees", {31'b0, to}, {31'b0, v.exp_to});
        chk("calc_en_resp", {31'b0, calc_en}, 32'd0);
        chk("calc_hold", hold_err_cnt - herr0, 32'd0);
        chk("ready_low_busy", {31'b0, rdy_err}, 32'd0);
        d0 = rsp_data; o0 = rsp_op; t0 = rsp_timeout; stab_err = 1'b0;
        repeat (v.delay) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== d0 || rsp_op !== o0 || rsp_timeout !== t0 ||
                cmd_ready !== 1'b0) stab_err = 1'b1;
        end
        if (v.delay > 0) chk("backpressure_stable", {31'b0, stab_err}, 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        if (v.exp_to) n_to++; else n_done++;
        chk("rsp_valid_drop", {31'b0, rsp_valid}, 32'd0);
        chk("cmd_ready_back", {31'b0, cmd_ready}, 32'd1);
        chk("busy_drop", {31'b0, busy}, 32'd0);
`ifdef FP_SEQ_STATS_EN
        chk("stat_done", {16'b0, stat_done}, n_done);
        chk("stat_timeout", {16'b0, stat_timeout}, n_to);
`else
        chk("stat_tied", {stat_done, stat_timeout}, 32'd0);
`endif
    endtask

    vec_t tbl[8];
    vec_t rv;
    bit   rv_to;
    int   rv_lat;
    bit   bad;

    initial begin
        tbl[0] = '{2'b00, 32'h3F800000, 32'h40000000, 32'h40400000, 0, 1, 0, 0, 32'h40400000, 0};
        tbl[1] = '{2'b10, 32'h40000000, 32'h40400000, 32'h40C00000, 0, 1, 0, 0, 32'h40C00000, 0};
        tbl[2] = '{2'b01, 32'h40400000, 32'h3F800000, 32'h40000000, 0, 1, 0, 0, 32'h40000000, 0};
        tbl[3] = '{2'b11, 32'h40C00000, 32'h40000000, 32'h40400000, 2, 10, 0, 0, 32'h40400000, 0};
        tbl[4] = '{2'b11, 32'h3F800000, 32'h00000000, 32'h12345678, 0, 1, 1, 0, 32'h7FC00000, 1};
        tbl[5] = '{2'b11, 32'h41000000, 32'h40000000, 32'h40800000, 0, 63, 0, 0, 32'h40800000, 0};
        tbl[6] = '{2'b11, 32'h41000000, 32'h40000000, 32'h40800000, 0, 64, 0, 0, 32'h7FC00000, 1};
        tbl[7] = '{2'b00, 32'h40000000, 32'h40000000, 32'h40800000, 0, 1, 0, 5, 32'h40800000, 0};

        rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_op = '0; cmd_a = '0; cmd_b = '0;
        repeat (3) @(negedge clk);
        chk("reset_calc_en", {31'b0, calc_en}, 32'd0);
        chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_misc", {calc_op, rsp_op, rsp_timeout, 27'b0}, 32'd0);
        chk("reset_calc_a", calc_a | calc_b, 32'd0);
        chk("reset_stats", {stat_done, stat_timeout}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("cmd_ready_after_reset", {31'b0, cmd_ready}, 32'd1);

        for (int i = 0; i < 8; i++) run_txn(tbl[i]);

        // Reset while in WAIT abandons the operation.
        cur_op = 2'b00; cur_a = 32'hAAAA5555; cur_b = 32'h5555AAAA; cur_res = 32'h0BADF00D;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = cur_op; cmd_a = cur_a; cmd_b = cur_b;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("in_wait_calc_en", {31'b0, calc_en}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_calc_en_now", {31'b0, calc_en}, 32'd0);
        chk("rst_busy_now", {31'b0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0; n_to = 0;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || calc_en !== 1'b0) bad = 1'b1;
        end
        chk("no_rsp_after_rst", {31'b0, bad}, 32'd0);
        chk("cmd_ready_after_rst", {31'b0, cmd_ready}, 32'd1);
        chk("stats_cleared", {stat_done, stat_timeout}, 32'd0);

        for (int i = 0; i < 30; i++) begin
            rv.op    = 2'($urandom);
            rv.a     = $urandom;
            rv.b     = $urandom;
            rv.res   = $urandom;
            rv.stale = int'($urandom_range(0, 3));
            rv.gap   = int'($urandom_range(1, 70));
            rv.stuck = ($urandom_range(0, 7) == 0);
            rv.delay = int'($urandom_range(0, 4));
            rv_lat   = model_lat(rv.op, rv.stale, rv.gap, rv.stuck, rv_to);
            rv.exp_to   = rv_to;
            rv.exp_data = rv_to ? 32'h7FC00000 : rv.res;
            run_txn(rv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_calc_sequencer.md
Name: fp_calc_sequencer

Overview:
- Command-side initiator for the floating-point calculator top.
- Accepts operand/opcode commands on a valid/ready interface and drives inA/inB/op/en into the calculator.
- Waits a fixed pipeline latency for add/sub/mul, or for `finish` on divide, with a timeout.
- Returns the captured result on a valid/ready response interface; one operation in flight at a time.

Parameters:
- FIXED_LAT, 3, cycles from first WAIT cycle until calc_out is valid for op 00/01/10 (covers the top-level input and output registers); legal range 1..255.
- TIMEOUT_CYCLES, 64, maximum WAIT cycles for divide before abort; legal range 2..255.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  2  00 add, 01 sub, 10 mul, 11 div
- cmd_a  in  32  operand A, IEEE-754 single
- cmd_b  in  32  operand B, IEEE-754 single
- calc_a  out  32  to calculator inA
- calc_b  out  32  to calculator inB
- calc_op  out  2  to calculator op
- calc_en  out  1  to calculator en
- calc_out  in  32  calculator result
- calc_finish  in  1  calculator divide-complete flag
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  32  result, or qNaN on timeout
- rsp_op  out  2  opcode of the completed command
- rsp_timeout  out  1  response produced by timeout
- busy  out  1  high in any state other than IDLE
- stat_done  out  16  see Optional Feature
- stat_timeout  out  16  see Optional Feature

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - calc_a, calc_b, calc_op, calc_en, rsp_valid, rsp_data, rsp_op, rsp_timeout, busy, the counters and the arm flag are all 0.
  - cmd_ready reads 1 once rst deasserts.
  - Reset mid-operation abandons the operation; no response is issued.
- All outputs are registered except cmd_ready, which equals (state==IDLE).
- State IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready: latch cmd_a/b/op into calc_a/b/op, then go to ISSUE.
- State ISSUE (1 cycle):
  - calc_en=1.
  - Clear cnt and arm.
  - Go to WAIT.
- State WAIT:
  - calc_en=1; calc_a/b/op held stable.
  - cnt increments by 1 every cycle.
  - Non-divide ops: when cnt==FIXED_LAT-1, capture calc_out into rsp_data, set rsp_timeout=0, go to RESP.
  - Divide: arm is set by any WAIT cycle with calc_finish=0. A stale finish held high from the previous divide is therefore ignored.
  - Divide completes on the first cycle with arm=1 (registered) and calc_finish=1: capture calc_out, go to RESP.
  - Divide timeout: if cnt==TIMEOUT_CYCLES-1 without completion, rsp_data=32'h7FC00000, rsp_timeout=1, go to RESP.
  - If completion and timeout occur in the same cycle, completion wins.
- State RESP:
  - calc_en=0; rsp_valid=1.
  - rsp_data, rsp_op and rsp_timeout are held stable while rsp_ready=0.
  - On rsp_ready: rsp_valid falls next cycle and state returns to IDLE.
  - A new command is accepted no earlier than the cycle after that return (no overlap).
- Latency, non-divide, with cmd accepted in cycle 0 and rsp_ready held 1:
  - ISSUE is cycle 1.
  - WAIT is cycles 2..FIXED_LAT+1.
  - rsp_valid is high in cycle FIXED_LAT+2.
- Commands are never dropped: while cmd_ready=0 the upstream holds cmd_valid and data.
- cnt is 8 bits and never wraps, since both limits are ≤255.

Optional Feature:
- Macro: FP_SEQ_STATS_EN.
- Defined:
  - stat_done counts response handshakes with rsp_timeout=0.
  - stat_timeout counts response handshakes with rsp_timeout=1.
  - Both are 16-bit, saturate at 16'hFFFF, and clear on rst.
- Undefined: both ports are tied to 0 and no counter logic is generated.

Test Plan:
- Add: cmd_op=00, a=32'h3F800000, b=32'h40000000, model result after FIXED_LAT=3 → rsp_data=32'h40400000, rsp_timeout=0, rsp_valid high in cycle 5 after accept.
- Mul then sub back-to-back:
  - Mul: a=32'h40000000, b=32'h40400000 → rsp_data=32'h40C00000.
  - Sub: a=32'h40400000, b=32'h3F800000 → rsp_data=32'h40000000.
  - cmd_ready stays low between accept and each response handshake.
- Divide: a=32'h40C00000, b=32'h40000000; model holds finish high from the previous op for 2 WAIT cycles, drops it, then raises it 10 cycles later → stale finish ignored, rsp_data=32'h40400000, rsp_op=11.
- Divide timeout: calc_finish stuck 0 → after TIMEOUT_CYCLES WAIT cycles, rsp_data=32'h7FC00000, rsp_timeout=1; with FP_SEQ_STATS_EN, stat_timeout=1.
- Backpressure and reset:
  - Hold rsp_ready=0 for 5 cycles in RESP → rsp_data, rsp_valid, cmd_ready=0 all stable.
  - Separately, assert rst in WAIT → calc_en=0 immediately, no rsp_valid afterwards, cmd_ready=1 after release.
